// File: rtl/cnn_cell_state_if.sv
// Cell-output / template-sum handshake between cnn_cell_state (master) and
// the neighbourhood/template stage (slave).
interface cnn_cell_state_if #(
  parameter int unsigned SUM_W = 17,
  parameter int unsigned Y_W   = 9
);
  logic signed [Y_W-1:0]   y_out;
  logic                    y_valid;
  logic                    y_ready;
  logic signed [SUM_W-1:0] sum_in;
  logic                    sum_valid;

  modport master (
    output y_out, y_valid,
    input  y_ready, sum_in, sum_valid
  );

  modport slave (
    input  y_out, y_valid,
    output y_ready, sum_in, sum_valid
  );
endinterface

// File: rtl/cnn_cell_state.sv
// CNN cell state integrator: forward-Euler update of x from the template sum,
// saturated output y offered back to the template stage until x settles.
module cnn_cell_state #(
  parameter int unsigned SUM_W      = 17,
  parameter int unsigned Y_W        = 9,
  parameter int unsigned DT_SHIFT   = 3,
  parameter int unsigned YMAX       = 128,
  parameter int unsigned MAX_ITER   = 64,
  parameter int unsigned TOL        = 1,
  parameter int unsigned STABLE_CNT = 4,
  parameter int unsigned ITER_W     = 7
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic signed [SUM_W-1:0] x_init,
  cnn_cell_state_if.master        cif,
  output logic                    busy,
  output logic                    done,
  output logic                    converged,
  output logic [ITER_W-1:0]       iter_count
);

  localparam int unsigned ST_W = $clog2(STABLE_CNT + 1);

  localparam logic signed [SUM_W+1:0] XMAX   = (SUM_W+2)'((2**(SUM_W-1)) - 1);
  localparam logic signed [SUM_W+1:0] XMIN   = -((SUM_W+2)'(2**(SUM_W-1)));
  localparam logic signed [SUM_W:0]   TOL_P  = (SUM_W+1)'(TOL);
  localparam logic signed [SUM_W:0]   TOL_N  = -((SUM_W+1)'(TOL));
  localparam logic signed [SUM_W-1:0] YMAX_X = SUM_W'(YMAX);
  localparam logic signed [SUM_W-1:0] YMIN_X = -(SUM_W'(YMAX));

  typedef enum logic [1:0] {IDLE, EMIT, WAIT, DONE} state_t;

  state_t                  state;
  logic signed [SUM_W-1:0] x;
  logic [ST_W-1:0]         stable;

  logic signed [SUM_W:0]   diff;
  logic signed [SUM_W:0]   delta;
  logic signed [SUM_W+1:0] xsum;
  logic signed [SUM_W-1:0] x_next;
  logic                    in_tol;
  logic [ST_W-1:0]         stable_next;
  logic [ITER_W-1:0]       iter_next;

  function automatic logic signed [Y_W-1:0] clamp(input logic signed [SUM_W-1:0] v);
    if (v > YMAX_X)      return Y_W'(YMAX_X);
    else if (v < YMIN_X) return Y_W'(YMIN_X);
    else                 return Y_W'(v);
  endfunction

  // Difference is taken one bit wider so sum - x cannot overflow; the
  // arithmetic shift then floors toward -inf.
  always_comb begin
    diff        = (SUM_W+1)'(cif.sum_in) - (SUM_W+1)'(x);
    delta       = diff >>> DT_SHIFT;
    xsum        = (SUM_W+2)'(x) + (SUM_W+2)'(delta);
    if (xsum > XMAX)      x_next = SUM_W'(XMAX);
    else if (xsum < XMIN) x_next = SUM_W'(XMIN);
    else                  x_next = SUM_W'(xsum);
    in_tol      = (delta <= TOL_P) && (delta >= TOL_N);
    stable_next = in_tol ? stable + ST_W'(1) : '0;
    iter_next   = iter_count + ITER_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      x           <= '0;
      stable      <= '0;
      iter_count  <= '0;
      cif.y_out   <= '0;
      cif.y_valid <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      converged   <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state       <= EMIT;
            x           <= x_init;
            cif.y_out   <= clamp(x_init);
            cif.y_valid <= 1'b1;
            iter_count  <= '0;
            stable      <= '0;
            busy        <= 1'b1;
            done        <= 1'b0;
            converged   <= 1'b0;
          end
        end
        EMIT: begin
          if (cif.y_ready) begin
            state       <= WAIT;
            cif.y_valid <= 1'b0;
          end
        end
        WAIT: begin
          if (cif.sum_valid) begin
            x          <= x_next;
            cif.y_out  <= clamp(x_next);
            iter_count <= iter_next;
            stable     <= stable_next;
            // Convergence is tested first so it wins on the capping iteration.
            if (stable_next == ST_W'(STABLE_CNT)) begin
              state     <= DONE;
              converged <= 1'b1;
              busy      <= 1'b0;
              done      <= 1'b1;
            end else if (iter_next == ITER_W'(MAX_ITER)) begin
              state     <= DONE;
              converged <= 1'b0;
              busy      <= 1'b0;
              done      <= 1'b1;
            end else begin
              state       <= EMIT;
              cif.y_valid <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
